// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences loads and byte/half/word stores onto a word-addressed
// memory. Sub-word stores are performed as read-modify-write.
`timescale 1ns/1ps
`default_nettype none

module mem_access_unit #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] memory_data_register_out,
   output logic        done,
   output logic        err
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   state_t         state_q;
   logic           ready_q;
   logic           write_q;
   logic [1:0]     size_q;
   logic [1:0]     lane_q;
   logic [15:0]    wdata_q;
   logic [CW-1:0]  cnt_q;
   logic [31:0]    mem_addr_q;
   logic           mem_rd_q;
   logic           mem_wr_q;
   logic [31:0]    mem_wdata_q;
   logic [31:0]    mdr_q;
   logic           done_q;
   logic           err_q;

   logic           misaligned_d;
   logic [4:0]     shift_d;
   logic [31:0]    shifted_d;
   logic [31:0]    load_d;
   logic [31:0]    lane_mask_d;
   logic [31:0]    lane_data_d;
   logic [31:0]    merge_d;

   assign misaligned_d = (req_size == 2'b11) ||
                         ((req_size == 2'b01) && req_addr[0]) ||
                         ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

   assign shift_d   = {lane_q, 3'b000};
   assign shifted_d = mem_rdata >> shift_d;

   always_comb begin
      load_d = shifted_d;
      case (size_q)
         2'b00:   load_d = {24'd0, shifted_d[7:0]};
         2'b01:   load_d = {16'd0, shifted_d[15:0]};
         default: load_d = shifted_d;
      endcase
   end

   // Replicate the store data across every lane, then keep only the target lane(s).
   always_comb begin
      lane_mask_d = 32'h0000_00FF << shift_d;
      lane_data_d = {4{wdata_q[7:0]}};
      if (size_q == 2'b01) begin
         lane_mask_d = 32'h0000_FFFF << shift_d;
         lane_data_d = {2{wdata_q[15:0]}};
      end
      merge_d = (mem_rdata & ~lane_mask_d) | (lane_data_d & lane_mask_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b1;
         write_q     <= 1'b0;
         size_q      <= 2'b00;
         lane_q      <= 2'b00;
         wdata_q     <= 16'd0;
         cnt_q       <= '0;
         mem_addr_q  <= 32'd0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= 32'd0;
         mdr_q       <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  ready_q    <= 1'b0;
                  write_q    <= req_write;
                  size_q     <= req_size;
                  lane_q     <= req_addr[1:0];
                  wdata_q    <= req_wdata[15:0];
                  mem_addr_q <= {req_addr[31:2], 2'b00};
                  cnt_q      <= CW'(MEM_LATENCY - 1);
                  if (misaligned_d) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (req_write && (req_size == 2'b10)) begin
                     state_q     <= ST_WRITE;
                     mem_wr_q    <= 1'b1;
                     mem_wdata_q <= req_wdata;
                  end else begin
                     state_q  <= ST_READ;
                     mem_rd_q <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (cnt_q == '0) begin
                  mem_rd_q <= 1'b0;
                  if (write_q) begin
                     state_q     <= ST_WRITE;
                     mem_wr_q    <= 1'b1;
                     mem_wdata_q <= merge_d;
                  end else begin
                     state_q <= ST_FINISH;
                     mdr_q   <= load_d;
                     done_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            ST_WRITE: begin
               mem_wr_q <= 1'b0;
               state_q  <= ST_FINISH;
               done_q   <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready                = ready_q;
   assign mem_addr                 = mem_addr_q;
   assign mem_rd                   = mem_rd_q;
   assign mem_wr                   = mem_wr_q;
   assign mem_wdata                = mem_wdata_q;
   assign memory_data_register_out = mdr_q;
   assign done                     = done_q;
   assign err                      = err_q;

endmodule

`default_nettype wire
